// File: rtl/router_reg_if.sv
// Signal bundle between the router FSM/source (master) and the router datapath register block (slave).
// Carries the per-byte strobes and the packet byte; dout goes on to the selected output FIFO.
interface router_reg_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       lfd_state;
  logic       rst_int_reg;
  logic       err;
  logic       parity_done;
  logic       low_packet_valid;
  logic [7:0] dout;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, ld_state, laf_state,
           full_state, lfd_state, rst_int_reg,
    input  err, parity_done, low_packet_valid, dout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, ld_state, laf_state,
           full_state, lfd_state, rst_int_reg,
    output err, parity_done, low_packet_valid, dout
  );
endinterface

// File: rtl/router_reg.sv
// Router datapath registers: header latch, byte streaming to dout with one-cycle latency, running parity check.
// A byte arriving while the FIFO is full is parked in r_full_byte and replayed in LOAD_AFTER_FULL.
module router_reg (
  input  logic        clock,
  input  logic        resetn,
  router_reg_if.slave bus
);

  logic [7:0] r_header_byte;
  logic [7:0] r_full_byte;
  logic [7:0] r_int_parity;
  logic [7:0] r_pkt_parity;
  logic [7:0] r_dout;
  logic       r_err;
  logic       r_parity_done;
  logic       r_low_packet_valid;

  logic w_hdr_capture;
  logic w_ld_parity;
  logic w_pd_set;

  assign w_hdr_capture = bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != 2'b11);
  // pkt_valid low during LOAD_DATA marks the trailing parity byte
  assign w_ld_parity   = bus.ld_state && !bus.pkt_valid;
  assign w_pd_set      = (w_ld_parity && !bus.fifo_full) ||
                         (bus.laf_state && r_low_packet_valid && !r_parity_done);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_header_byte <= 8'h00;
    end else if (w_hdr_capture) begin
      r_header_byte <= bus.data_in;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_dout      <= 8'h00;
      r_full_byte <= 8'h00;
    end else if (bus.lfd_state) begin
      r_dout <= r_header_byte;
    end else if (bus.ld_state && !bus.fifo_full) begin
      r_dout <= bus.data_in;
    end else if (bus.ld_state && bus.fifo_full) begin
      r_full_byte <= bus.data_in;
    end else if (bus.laf_state) begin
      r_dout <= r_full_byte;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_int_parity <= 8'h00;
    end else if (bus.detect_add) begin
      r_int_parity <= 8'h00;
    end else if (bus.lfd_state) begin
      r_int_parity <= r_int_parity ^ r_header_byte;
    end else if (bus.ld_state && bus.pkt_valid && !bus.full_state) begin
      r_int_parity <= r_int_parity ^ bus.data_in;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pkt_parity <= 8'h00;
    end else if (bus.detect_add) begin
      r_pkt_parity <= 8'h00;
    end else if (w_ld_parity) begin
      r_pkt_parity <= bus.data_in;
    end
  end

  // Deliberately not cleared by detect_add: only the FSM's rst_int_reg drops it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_low_packet_valid <= 1'b0;
    end else if (bus.rst_int_reg) begin
      r_low_packet_valid <= 1'b0;
    end else if (w_ld_parity) begin
      r_low_packet_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_parity_done <= 1'b0;
      r_err         <= 1'b0;
    end else if (bus.detect_add) begin
      r_parity_done <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_pd_set) begin
        r_parity_done <= 1'b1;
      end
      if (r_parity_done) begin
        r_err <= (r_int_parity != r_pkt_parity);
      end
    end
  end

  assign bus.dout             = r_dout;
  assign bus.err              = r_err;
  assign bus.parity_done      = r_parity_done;
  assign bus.low_packet_valid = r_low_packet_valid;

endmodule

// File: tb/tb_router_reg.sv
// Bench for router_reg: FSM-like packet stimulus with a queue of expected FIFO bytes and parity verdicts.
// A monitor pops and compares whenever a strobe makes dout load or parity_done rises.
module tb_router_reg;

  logic clock;
  logic resetn;

  router_reg_if u_if ();

  router_reg dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (u_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic       err;
  } exp_t;

  exp_t       q_exp[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] m_hdr    = 8'h00;
  bit         lpv_dirty = 1'b0;
  bit         err_pend  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input logic da, input logic lfd, input logic ld, input logic laf,
                       input logic fs, input logic pv, input logic ff, input logic rir,
                       input logic [7:0] d);
    u_if.detect_add  = da;
    u_if.lfd_state   = lfd;
    u_if.ld_state    = ld;
    u_if.laf_state   = laf;
    u_if.full_state  = fs;
    u_if.pkt_valid   = pv;
    u_if.fifo_full   = ff;
    u_if.rst_int_reg = rir;
    u_if.data_in     = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic full_seq(input logic pv, input logic [7:0] d);
    drive(0, 0, 0, 0, 1, pv, 0, 0, d); step();
    drive(0, 0, 0, 1, 0, pv, 0, 0, d); step();
  endtask

  // full_idx: -1 none, 0..len-1 payload byte, len = parity byte
  task automatic send_pkt(input logic [1:0] addr, input int len, input bit bad,
                          input int full_idx, input int a5_idx, input bit pulse_rir);
    logic [7:0] pl[$];
    logic [7:0] hdr, par, ref_par, p;
    bit         exp_err;
    hdr = {6'(len), addr};
    par = hdr;
    for (int i = 0; i < len; i++) begin
      p = (i == a5_idx) ? 8'hA5 : 8'($urandom);
      pl.push_back(p);
      par ^= p;
    end
    if (bad) par ^= 8'h01;
    if (full_idx >= 0 && lpv_dirty) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 8'h00); step();
      lpv_dirty = 1'b0;
    end
    if (addr != 2'b11) m_hdr = hdr;
    ref_par = m_hdr;
    foreach (pl[i]) ref_par ^= pl[i];
    exp_err = (ref_par != par);

    drive(1, 0, 0, 0, 0, 1, 0, 0, hdr); step();
    drive(0, 1, 0, 0, 0, 1, 0, 0, pl[0]);
    q_exp.push_back('{b: m_hdr, last: 1'b0, err: 1'b0});
    step();
    for (int i = 0; i < len; i++) begin
      drive(0, 0, 1, 0, 0, 1, (i == full_idx), 0, pl[i]);
      q_exp.push_back('{b: pl[i], last: 1'b0, err: 1'b0});
      step();
      if (i == full_idx) full_seq(1'b1, pl[i]);
    end
    drive(0, 0, 1, 0, 0, 0, (full_idx == len), 0, par);
    q_exp.push_back('{b: par, last: 1'b1, err: exp_err});
    step();
    if (full_idx == len) full_seq(1'b0, par);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00); step(); step();
    lpv_dirty = 1'b1;
    if (pulse_rir) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 8'h00); step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00); step();
      lpv_dirty = 1'b0;
    end
  endtask

  // Monitor / scoreboard
  logic       s_rs, s_load, s_det, s_rir, s_ldp, prev_pd, got_last, exp_err_v;
  logic       model_lpv, model_pd, model_err;
  logic [7:0] last_exp;
  exp_t       e;

  initial begin
    prev_pd = 0; model_lpv = 0; model_pd = 0; model_err = 0; last_exp = 8'h00; exp_err_v = 0;
    forever begin
      @(posedge clock);
      s_rs   = resetn;
      s_load = u_if.lfd_state || (u_if.ld_state && !u_if.fifo_full) || u_if.laf_state;
      s_det  = u_if.detect_add;
      s_rir  = u_if.rst_int_reg;
      s_ldp  = u_if.ld_state && !u_if.pkt_valid;
      @(negedge clock);
      if (!resetn || !s_rs) begin
        prev_pd = 0; model_lpv = 0; model_pd = 0; model_err = 0; last_exp = 8'h00;
        err_pend = 1'b0;
      end else begin
        if (s_rir) model_lpv = 1'b0;
        else if (s_ldp) model_lpv = 1'b1;
        if (err_pend) begin
          chk("err_verdict", 32'(u_if.err), 32'(exp_err_v));
          model_err = exp_err_v;
          err_pend = 1'b0;
        end
        got_last = 1'b0;
        if (s_load) begin
          if (q_exp.size() == 0) begin
            chk("dout_unexpected_load", 32'(q_exp.size()), 32'd1);
          end else begin
            e = q_exp.pop_front();
            chk("dout", 32'(u_if.dout), 32'(e.b));
            last_exp = e.b;
            got_last = e.last;
            exp_err_v = e.err;
          end
        end else begin
          chk("dout_hold", 32'(u_if.dout), 32'(last_exp));
        end
        if (u_if.parity_done && !prev_pd) begin
          chk("pd_with_parity_byte", 32'(got_last), 32'd1);
          chk("lpv_at_pd", 32'(u_if.low_packet_valid), 32'd1);
          err_pend = 1'b1;
          model_pd = 1'b1;
        end
        if (s_det) begin
          chk("err_clr_on_detect", 32'(u_if.err), 32'd0);
          chk("pd_clr_on_detect", 32'(u_if.parity_done), 32'd0);
          chk("lpv_across_detect", 32'(u_if.low_packet_valid), 32'(model_lpv));
          model_err = 1'b0;
          model_pd = 1'b0;
        end
        if (s_rir) begin
          chk("lpv_after_rst_int", 32'(u_if.low_packet_valid), 32'd0);
          chk("err_kept_rst_int", 32'(u_if.err), 32'(model_err));
          chk("pd_kept_rst_int", 32'(u_if.parity_done), 32'(model_pd));
        end
        prev_pd = u_if.parity_done;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, 32'(u_if.dout), 32'd0);
    chk({tag, "_err"}, 32'(u_if.err), 32'd0);
    chk({tag, "_pd"}, 32'(u_if.parity_done), 32'd0);
    chk({tag, "_lpv"}, 32'(u_if.low_packet_valid), 32'd0);
  endtask

  initial begin
    int len, fidx;
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    #3;
    chk_zero("reset");
    step(); step();
    resetn = 1'b1;
    step();

    send_pkt(2'd2, 5, 1'b0, -1, -1, 1'b1);
    send_pkt(2'd2, 5, 1'b1, -1, -1, 1'b0);
    send_pkt(2'd3, 3, 1'b0, -1, -1, 1'b1);
    send_pkt(2'd1, 4, 1'b0, 2, 2, 1'b1);
    send_pkt(2'd0, 2, 1'b0, 2, -1, 1'b1);

    // Async reset in the middle of a payload
    drive(1, 0, 0, 0, 0, 1, 0, 0, 8'h09); m_hdr = 8'h09; step();
    drive(0, 1, 0, 0, 0, 1, 0, 0, 8'h3C);
    q_exp.push_back('{b: 8'h09, last: 1'b0, err: 1'b0});
    step();
    drive(0, 0, 1, 0, 0, 1, 0, 0, 8'h3C);
    q_exp.push_back('{b: 8'h3C, last: 1'b0, err: 1'b0});
    step();
    #2;
    resetn = 1'b0;
    #1;
    chk_zero("async_reset");
    q_exp.delete();
    m_hdr = 8'h00;
    lpv_dirty = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    step(); step();
    resetn = 1'b1;
    step();

    for (int k = 0; k < 25; k++) begin
      len  = int'($urandom_range(1, 8));
      fidx = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, len));
      send_pkt(2'($urandom_range(0, 3)), len, 1'($urandom_range(0, 1)), fidx, -1,
               1'($urandom_range(0, 1)));
    end

    step(); step(); step();
    chk("queue_drained", 32'(q_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_reg.md
# router_reg

Datapath register block of the 1x3 packet router, sitting between the router FSM and the three output FIFOs. It latches the header byte and streams header and payload bytes to `dout` under FSM state strobes. It holds back one byte when the FIFO is full, computes running XOR parity over header and payload, and flags a parity error against the packet's trailing parity byte.

## Interface
- No parameters.
- `clock`  in  1  Single clock; all state updates on the rising edge.
- `resetn`  in  1  Reset, asynchronous and active-low; clears all registers.
- `pkt_valid`  in  1  High while header and payload bytes are on `data_in`; low on the parity byte.
- `data_in`  in  8  Packet byte. Header is {len[5:0], addr[1:0]}.
- `fifo_full`  in  1  Target FIFO full.
- `detect_add`  in  1  FSM is in DECODE_ADDRESS.
- `ld_state`  in  1  FSM is in LOAD_DATA.
- `laf_state`  in  1  FSM is in LOAD_AFTER_FULL.
- `full_state`  in  1  FSM is in FIFO_FULL_STATE.
- `lfd_state`  in  1  FSM is in LOAD_FIRST_DATA.
- `rst_int_reg`  in  1  Clears `low_packet_valid`.
- `err`  out  1  Parity mismatch flag.
- `parity_done`  out  1  Parity byte has been captured.
- `low_packet_valid`  out  1  `pkt_valid` has fallen during LOAD_DATA.
- `dout`  out  8  Byte to the FIFO.

## Operation
- Internal registers, all 8 bits: `header_byte`, `full_byte`, `int_parity`, `pkt_parity`.
- Header capture: if `detect_add && pkt_valid && data_in[1:0] != 2'b11`, then `header_byte <= data_in`.
- `dout` priority, first match wins:
  - `lfd_state`: `dout <= header_byte`.
  - `ld_state && !fifo_full`: `dout <= data_in`.
  - `ld_state && fifo_full`: `full_byte <= data_in`; `dout` holds.
  - `laf_state`: `dout <= full_byte`.
  - Otherwise `dout` holds.
- `int_parity`:
  - Cleared on `detect_add`.
  - On `lfd_state`: `int_parity ^= header_byte`.
  - On `ld_state && pkt_valid && !full_state`: `int_parity ^= data_in`.
- `pkt_parity`: cleared on `detect_add`; on `ld_state && !pkt_valid`, `pkt_parity <= data_in`.
- `low_packet_valid`:
  - Cleared on `rst_int_reg`.
  - Otherwise set on `ld_state && !pkt_valid`.
  - Otherwise holds.
- `parity_done`:
  - Cleared on `detect_add`.
  - Set on `(ld_state && !fifo_full && !pkt_valid)` or `(laf_state && low_packet_valid && !parity_done)`.
  - Otherwise holds.
- `err`:
  - Cleared on `detect_add`.
  - When `parity_done` is 1: `err <= (int_parity != pkt_parity)`.
  - Otherwise holds.
- Simultaneous strobes: `detect_add` clears take precedence over set conditions in the same register.

## Timing
- Reset (async, `resetn=0`): `dout=0`, `err=0`, `parity_done=0`, `low_packet_valid=0`, and all internal registers 0. Reset mid-packet aborts the packet; outputs are 0 on the next observation.
- Packet of length N, with the header presented with `detect_add` at edge E1:
  - E2 (`lfd`): `dout` = header.
  - E3..E(N+2): `dout` = payload bytes, one-cycle latency from `data_in`.
  - E(N+3) (`ld`, `pkt_valid=0`): `dout` = parity byte; `pkt_parity`, `low_packet_valid` and `parity_done` go to 1.
  - E(N+4): `err` valid.
- Byte held on full: `full_byte` is presented on `dout` one edge after `laf_state`.
- `low_packet_valid` stays high until `rst_int_reg`, even across `detect_add`.

## Test plan
- Good packet: addr=2, len=5, five random payload bytes, correct XOR parity. Required: `dout` sequence is header 0x16, then the payloads, then parity; `parity_done=1` the edge after the parity byte; `err=0` one edge later; `low_packet_valid=1`.
- Bad parity: same packet with the parity byte XOR 0x01. Required: `err=1` one edge after `parity_done` rises; `err` clears on the next `detect_add`.
- FIFO full: `fifo_full=1` during the third payload byte 0xA5, then `full_state`, then `laf_state`. Required: `dout` holds during full; `dout=0xA5` after `laf_state`; the parity result is still correct.
- Address 3: header 0x17 with `detect_add`. Required: `header_byte` unchanged, so a following `lfd_state` drives the previous header.
- `rst_int_reg` pulse after the packet. Required: `low_packet_valid` returns to 0; `err` and `parity_done` unaffected.
- Assert `resetn=0` asynchronously mid-payload. Required: all outputs 0 immediately, with no clock edge needed.
